parity_lane_gen_chk: RTL and testbench

// - Streaming, parametrised per-lane parity generator/checker; successor to the fixed 8-bit combinational parity block.
// - DATA_W splits into LANES = DATA_W/LANE_W lanes; one parity bit per lane; even/odd selectable per beat.
// - Generate mode appends parity; check mode compares the supplied parity, flags errors and counts them.
// - Sits between a ready/valid source and sink; one registered stage with full throughput.

---
 rtl/parity_lane_gen_chk_if.sv | 34 +++
 rtl/parity_lane_gen_chk.sv | 92 +++++++++
 tb/tb_parity_lane_gen_chk.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_lane_gen_chk_if.sv
// Ready/valid bus for parity_lane_gen_chk: source-side beat, sink-side beat, error counter access.
// The slave modport is the parity block's view; master is the surrounding source/sink.
interface parity_lane_gen_chk_if #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16
);
  localparam int LANES = DATA_W / LANE_W;

  logic              odd_mode;
  logic              chk_mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LANES-1:0]  in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LANES-1:0]  out_par;
  logic              out_err;
  logic [LANES-1:0]  err_lanes;
  logic              err_clr;
  logic [CNT_W-1:0]  err_cnt;

  modport slave (
    input  odd_mode, chk_mode, in_valid, in_data, in_par, out_ready, err_clr,
    output in_ready, out_valid, out_data, out_par, out_err, err_lanes, err_cnt
  );

  modport master (
    output odd_mode, chk_mode, in_valid, in_data, in_par, out_ready, err_clr,
    input  in_ready, out_valid, out_data, out_par, out_err, err_lanes, err_cnt
  );
endinterface

// File: rtl/parity_lane_gen_chk.sv
// Streaming per-lane parity generator/checker with one registered ready/valid stage.
// Optional saturating errored-beat counter enabled by defining PARITY_ERR_CNT_EN.
module parity_lane_gen_chk #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  parity_lane_gen_chk_if.slave bus
);
  localparam int LANES = DATA_W / LANE_W;

  generate
    if (LANE_W < 1 || (DATA_W % LANE_W) != 0) begin : g_bad_cfg
      $error("parity_lane_gen_chk: DATA_W must be a non-zero multiple of LANE_W");
    end
  endgenerate

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [LANES-1:0]  r_out_par;
  logic              r_out_err;
  logic [LANES-1:0]  r_err_lanes;

  logic [LANES-1:0]  w_par;
  logic [LANES-1:0]  w_mis;
  logic              w_err;
  logic              w_in_ready;
  logic              w_accept;

  always_comb begin
    // NOTE: assign a default before the loop so no path leaves w_par unassigned (no latch).
    w_par = '0;
    for (int i = 0; i < LANES; i++) begin
      w_par[i] = (^bus.in_data[i*LANE_W +: LANE_W]) ^ bus.odd_mode;
    end
  end

  assign w_mis      = {LANES{bus.chk_mode}} & (w_par ^ bus.in_par);
  assign w_err      = |w_mis;
  // Ready depends only on the output register, never on in_valid.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_par   <= '0;
      r_out_err   <= 1'b0;
      r_err_lanes <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data;
      r_out_par   <= bus.chk_mode ? bus.in_par : w_par;
      r_out_err   <= w_err;
      r_err_lanes <= w_mis;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (bus.err_clr) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;
  assign bus.err_cnt      = '0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_par   = r_out_par;
  assign bus.out_err   = r_out_err;
  assign bus.err_lanes = r_err_lanes;
endmodule

// File: tb/tb_parity_lane_gen_chk.sv
// Randomised self-checking bench for parity_lane_gen_chk (DATA_W=32, LANE_W=8, CNT_W=4).
// The reference model counts ones per lane and tracks the single output slot directly.
module tb_parity_lane_gen_chk;
  localparam int DATA_W = 32;
  localparam int LANE_W = 8;
  localparam int CNT_W  = 4;
  localparam int LANES  = DATA_W / LANE_W;

  logic clk;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  parity_lane_gen_chk_if #(.DATA_W(DATA_W), .LANE_W(LANE_W), .CNT_W(CNT_W)) bus ();

  parity_lane_gen_chk #(.DATA_W(DATA_W), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model of the output slot and the errored-beat counter.
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [LANES-1:0]  m_par;
  logic              m_err;
  logic [LANES-1:0]  m_lanes;
  logic [CNT_W-1:0]  m_cnt;

  function automatic logic [LANES-1:0] ref_par(input logic [DATA_W-1:0] d, input logic odd);
    logic [LANE_W-1:0] lane;
    ref_par = '0;
    for (int i = 0; i < LANES; i++) begin
      lane       = d[i*LANE_W +: LANE_W];
      ref_par[i] = (($countones(lane) % 2) == 1) ^ odd;
    end
  endfunction

  function automatic logic [45:0] exp_vec();
    return {m_valid, m_data, m_par, m_err, m_lanes, m_cnt};
  endfunction

  function automatic logic [45:0] dut_vec();
    return {bus.out_valid, bus.out_data, bus.out_par, bus.out_err, bus.err_lanes, bus.err_cnt};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_par = '0; m_err = 1'b0; m_lanes = '0; m_cnt = '0;
  endtask

  // Drive one clock of stimulus; returns in_ready as seen before the edge and as the model predicts it.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [LANES-1:0] p,
                       input logic odd, input logic chk, input logic ordy, input logic clr,
                       output logic rdy_seen, output logic rdy_exp);
    logic             acc;
    logic [LANES-1:0] gp;
    logic [LANES-1:0] mis;
    bus.in_valid = v; bus.in_data = d; bus.in_par = p;
    bus.odd_mode = odd; bus.chk_mode = chk; bus.out_ready = ordy; bus.err_clr = clr;
    #1;
    rdy_seen = bus.in_ready;
    rdy_exp  = !m_valid || ordy;
    acc      = v && rdy_exp;
    gp       = ref_par(d, odd);
    mis      = chk ? (gp ^ p) : '0;
    @(posedge clk);
`ifdef PARITY_ERR_CNT_EN
    if (clr) m_cnt = '0;
    else if (acc && (mis != 0) && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
`endif
    if (acc) begin
      m_valid = 1'b1; m_data = d; m_par = chk ? p : gp; m_lanes = mis; m_err = (mis != 0);
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #2;
  endtask

  task automatic test_reset();
    logic rs, re;
    reset = 1'b1;
    bus.in_valid = 0; bus.in_data = '0; bus.in_par = '0; bus.odd_mode = 0;
    bus.chk_mode = 0; bus.out_ready = 0; bus.err_clr = 0;
    model_reset();
    #12;
    n_vec++;
    if (dut_vec() !== '0) begin
      n_miss++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 46'h0);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #2;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_miss++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    // Load a beat, stall it, then reset mid-cycle.
    cycle(1, 32'hDEAD_BEEF, 4'h5, 0, 1, 0, 0, rs, re);
    cycle(1, 32'h1234_5678, 4'h0, 1, 0, 0, 0, rs, re);
    n_vec++;
    if (rs !== 1'b0) begin
      n_miss++; $display("FAIL stall_in_ready: got %b expected 0", rs);
    end
    reset = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (dut_vec() !== '0 || bus.in_ready !== 1'b1) begin
      n_miss++; $display("FAIL async_reset: got %h rdy %b expected %h rdy 1", dut_vec(), bus.in_ready, 46'h0);
    end
    bus.in_valid = 0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #2;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_miss++; $display("FAIL after_release: got rdy %b vld %b expected rdy 1 vld 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_gen_even();
    logic rs, re;
    cycle(1, 32'h0103_0700, 4'h0, 0, 0, 1, 0, rs, re);
    n_vec++;
    if ({bus.out_valid, bus.out_par, bus.out_err, bus.err_lanes} !== {1'b1, 4'b1010, 1'b0, 4'b0000}) begin
      n_miss++; $display("FAIL gen_even: got v%b par %b err %b lanes %b expected v1 par 1010 err 0 lanes 0000",
                         bus.out_valid, bus.out_par, bus.out_err, bus.err_lanes);
    end
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_miss++; $display("FAIL gen_even_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_gen_odd();
    logic rs, re;
    cycle(1, 32'h0000_0000, 4'h0, 1, 0, 1, 0, rs, re);
    n_vec++;
    if (bus.out_par !== 4'b1111 || bus.out_err !== 1'b0) begin
      n_miss++; $display("FAIL gen_odd_zero: got par %b err %b expected par 1111 err 0", bus.out_par, bus.out_err);
    end
    cycle(1, 32'hFFFF_FFFF, 4'h0, 0, 0, 1, 0, rs, re);
    n_vec++;
    if (bus.out_par !== 4'b0000 || bus.out_data !== 32'hFFFF_FFFF) begin
      n_miss++; $display("FAIL gen_even_ones: got par %b data %h expected par 0000 data ffffffff",
                         bus.out_par, bus.out_data);
    end
  endtask

  task automatic test_check();
    logic rs, re;
    cycle(1, 32'h0000_0001, 4'b0000, 0, 1, 1, 0, rs, re);
    n_vec++;
    if ({bus.out_err, bus.err_lanes, bus.out_par} !== {1'b1, 4'b0001, 4'b0000}) begin
      n_miss++; $display("FAIL check_err: got err %b lanes %b par %b expected err 1 lanes 0001 par 0000",
                         bus.out_err, bus.err_lanes, bus.out_par);
    end
    cycle(1, 32'h0000_0001, 4'b0001, 0, 1, 1, 0, rs, re);
    n_vec++;
    if ({bus.out_err, bus.err_lanes, bus.out_par} !== {1'b0, 4'b0000, 4'b0001}) begin
      n_miss++; $display("FAIL check_ok: got err %b lanes %b par %b expected err 0 lanes 0000 par 0001",
                         bus.out_err, bus.err_lanes, bus.out_par);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] seq [4] = '{32'hB0B0_0001, 32'hC0C0_0002, 32'hD0D0_0003, 32'hE0E0_0004};
    logic [45:0] held;
    logic rs, re;
    cycle(1, 32'hA0A0_A0A0, 4'h0, 0, 0, 1, 0, rs, re);
    held = exp_vec();
    // Source holds beat B while the sink stalls; modes wiggle and must not touch the held beat.
    for (int i = 0; i < 5; i++) begin
      cycle(1, seq[0], 4'h0, i[0], i[1], 0, 0, rs, re);
      n_vec++;
      if (rs !== 1'b0 || dut_vec() !== held) begin
        n_miss++; $display("FAIL stall_%0d: got rdy %b out %h expected rdy 0 out %h", i, rs, dut_vec(), held);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, seq[i], 4'h0, 0, 0, 1, 0, rs, re);
      n_vec++;
      if (rs !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== seq[i]) begin
        n_miss++; $display("FAIL drain_%0d: got rdy %b vld %b data %h expected rdy 1 vld 1 data %h",
                           i, rs, bus.out_valid, bus.out_data, seq[i]);
      end
    end
    cycle(0, '0, 4'h0, 0, 0, 1, 0, rs, re);
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== seq[3]) begin
      n_miss++; $display("FAIL drain_idle: got vld %b data %h expected vld 0 data %h",
                         bus.out_valid, bus.out_data, seq[3]);
    end
  endtask

  task automatic test_random();
    logic rs, re;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      cycle($urandom_range(0, 3) != 0, d, 4'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rs, re);
      n_vec++;
      if (rs !== re || dut_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL random_%0d: got rdy %b out %h expected rdy %b out %h", i, rs, dut_vec(), re, exp_vec());
      end
    end
  endtask

  task automatic test_counter();
    logic rs, re;
    logic [DATA_W-1:0] d;
    logic [CNT_W-1:0]  sat;
`ifdef PARITY_ERR_CNT_EN
    sat = 4'hF;
`else
    sat = 4'h0;
`endif
    cycle(0, '0, 4'h0, 0, 0, 1, 1, rs, re);
    for (int i = 0; i < 17; i++) begin
      d = $urandom;
      cycle(1, d, ref_par(d, 0) ^ 4'b0100, 0, 1, 1, 0, rs, re);
    end
    n_vec++;
    if (bus.err_cnt !== sat || bus.err_cnt !== m_cnt) begin
      n_miss++; $display("FAIL cnt_saturate: got %h expected %h", bus.err_cnt, sat);
    end
    d = $urandom;
    cycle(1, d, ~ref_par(d, 1), 1, 1, 1, 1, rs, re);
    n_vec++;
    if (bus.err_cnt !== 4'h0 || bus.out_err !== 1'b1) begin
      n_miss++; $display("FAIL cnt_clear: got cnt %h err %b expected cnt 0 err 1", bus.err_cnt, bus.out_err);
    end
    d = $urandom;
    cycle(1, d, ref_par(d, 0) ^ 4'b1000, 0, 1, 1, 0, rs, re);
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_miss++; $display("FAIL cnt_after_clear: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_gen_even();
    test_gen_odd();
    test_check();
    test_back_to_back();
    test_random();
    test_counter();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
